// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: receiver FSM state encoding,
// the legal oversampling range and the parity-type encodings.
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } rx_state_e;

    localparam int unsigned PRESC_MIN = 4;
    localparam int unsigned PRESC_MAX = 32;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // A prescale is usable only when it is even and inside the supported range;
    // an odd value would put the middle sample off-centre.
    function automatic logic presc_legal(input int unsigned presc);
        return (presc % 2 == 0) && (presc >= PRESC_MIN) && (presc <= PRESC_MAX);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Result bus from the UART receiver to the system controller.
//   data       : last completed byte (held until the next frame completes)
//   data_valid : one-cycle pulse, frame received without error
//   par_err    : one-cycle pulse, parity mismatch
//   stp_err    : one-cycle pulse, stop bit sampled low
// master = receiver side (drives), slave = controller side (observes).
// -----------------------------------------------------------------------------
interface uart_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data;
    logic              data_valid;
    logic              par_err;
    logic              stp_err;

    modport master (output data, output data_valid, output par_err, output stp_err);
    modport slave  (input  data, input  data_valid, input  par_err, input  stp_err);
endinterface

// File: rtl/uart_rx_sampler.sv
// -----------------------------------------------------------------------------
// uart_rx_sampler
// Per-bit tick counter and 3-sample majority vote.
//   i_ref_clk, i_rst_n : clock, async active-low reset
//   rx_s               : synchronized serial line
//   run                : counter enable; low holds tick_cnt at 0
//   presc              : ticks per bit for the current frame
//   bit_val            : majority of the three samples (valid with bit_strobe)
//   bit_strobe         : decision tick, tick == presc/2+1
//   bit_end            : last tick of the bit, tick == presc-1
// -----------------------------------------------------------------------------
module uart_rx_sampler #(
    parameter int PRESC_W = 6
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               rx_s,
    input  logic               run,
    input  logic [PRESC_W-1:0] presc,
    output logic               bit_val,
    output logic               bit_strobe,
    output logic               bit_end
);

    logic [PRESC_W-1:0] tick_cnt;
    logic [PRESC_W-1:0] half;
    logic               smp_a;
    logic               smp_b;

    assign half       = presc >> 1;
    assign bit_strobe = run && (tick_cnt == half + 1'b1);
    assign bit_end    = run && (tick_cnt == presc - 1'b1);

    // The third sample is the live line value on the decision tick itself.
    assign bit_val = (smp_a & smp_b) | (smp_a & rx_s) | (smp_b & rx_s);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tick_cnt <= '0;
            smp_a    <= 1'b1;
            smp_b    <= 1'b1;
        end else begin
            if (!run || bit_end) tick_cnt <= '0;
            else                 tick_cnt <= tick_cnt + 1'b1;

            if (run && tick_cnt == half - 1'b1) smp_a <= rx_s;
            if (run && tick_cnt == half)        smp_b <= rx_s;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// Oversampling UART receiver. Samples i_rx_in at i_prescale ticks per bit,
// deframes start / DATA_W data bits (LSB first) / optional parity / stop, and
// reports the byte and per-frame error pulses on rx_bus.
//   i_ref_clk, i_rst_n : clock (baud x prescale), async active-low reset
//   i_rx_in            : serial line, idle high, asynchronous
//   i_prescale         : ticks per bit, even 4..32; other values disable RX
//   i_par_en/i_par_typ : parity enable / 0 even, 1 odd
//   rx_bus             : data, data_valid, par_err, stp_err (registered)
// Frame settings are captured at the start edge and held for the whole frame.
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int PRESC_W = 6
) (
    input  logic               i_ref_clk,
    input  logic               i_rst_n,
    input  logic               i_rx_in,
    input  logic [PRESC_W-1:0] i_prescale,
    input  logic               i_par_en,
    input  logic               i_par_typ,
    uart_rx_if.master          rx_bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_e          state, state_nxt;
    logic               rx_meta, rx_s;
    logic [PRESC_W-1:0] presc_q;
    logic               pe_q, pt_q;
    logic [CNT_W-1:0]   bit_cnt;
    logic [DATA_W-1:0]  shreg;
    logic               par_fail;
    logic               start_det;
    logic               bit_val, bit_strobe, bit_end;

    logic [DATA_W-1:0]  data_q;
    logic               valid_q, par_err_q, stp_err_q;

    // Two-flop synchronizer; resets to the idle line level so reset release
    // cannot look like a start edge.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx_in;
            rx_s    <= rx_meta;
        end
    end

    assign start_det = (state == ST_IDLE) && !rx_s && presc_legal(32'(i_prescale));

    uart_rx_sampler #(.PRESC_W(PRESC_W)) u_sampler (
        .i_ref_clk  (i_ref_clk),
        .i_rst_n    (i_rst_n),
        .rx_s       (rx_s),
        .run        (state != ST_IDLE),
        .presc      (presc_q),
        .bit_val    (bit_val),
        .bit_strobe (bit_strobe),
        .bit_end    (bit_end)
    );

    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // NOTE: state_nxt gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (start_det) state_nxt = ST_START;
            // A high majority on the start bit is a glitch; checked before
            // bit_end because both coincide when the prescale is 4.
            ST_START:  if (bit_strobe && bit_val) state_nxt = ST_IDLE;
                       else if (bit_end)          state_nxt = ST_DATA;
            ST_DATA:   if (bit_end && bit_cnt == CNT_W'(DATA_W - 1))
                           state_nxt = pe_q ? ST_PARITY : ST_STOP;
            ST_PARITY: if (bit_end) state_nxt = ST_STOP;
            // Leave at the decision tick so back-to-back frames are caught.
            ST_STOP:   if (bit_strobe) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // Frame registers, deserializer and parity check.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_q  <= '0;
            pe_q     <= 1'b0;
            pt_q     <= PAR_EVEN;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_fail <= 1'b0;
        end else begin
            if (start_det) begin
                presc_q  <= i_prescale;
                pe_q     <= i_par_en;
                pt_q     <= i_par_typ;
                bit_cnt  <= '0;
                par_fail <= 1'b0;
            end
            if (state == ST_DATA) begin
                if (bit_strobe) shreg   <= {bit_val, shreg[DATA_W-1:1]};
                if (bit_end)    bit_cnt <= bit_cnt + 1'b1;
            end
            if (state == ST_PARITY && bit_strobe)
                par_fail <= bit_val != ((^shreg) ^ pt_q);
        end
    end

    // Result registers: pulses default low and fire on the stop decision.
    always_ff @(posedge i_ref_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_q    <= '0;
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
            if (state == ST_STOP && bit_strobe) begin
                data_q    <= shreg;
                stp_err_q <= !bit_val;
                par_err_q <= par_fail;
                valid_q   <= bit_val && !par_fail;
            end
        end
    end

    assign rx_bus.data       = data_q;
    assign rx_bus.data_valid = valid_q;
    assign rx_bus.par_err    = par_err_q;
    assign rx_bus.stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Directed bench for uart_rx. Inputs change on the falling clock edge; a
// monitor on the falling edge accumulates pulse counts, the cycle of the last
// pulse and a log of bytes delivered with data_valid.
// Pulse timing: line driven low right after posedge N lands the result pulse
// at cycle N + 4 + (9 + PE) * P + P/2 + 1 (2 sync flops, IDLE detect, then
// the stop decision tick plus one register stage).
// -----------------------------------------------------------------------------
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_in;
    logic [5:0] prescale;
    logic       par_en;
    logic       par_typ;

    uart_rx_if #(.DATA_W(8)) bus ();

    uart_rx #(.DATA_W(8), .PRESC_W(6)) dut (
        .i_ref_clk  (clk),
        .i_rst_n    (rst_n),
        .i_rx_in    (rx_in),
        .i_prescale (prescale),
        .i_par_en   (par_en),
        .i_par_typ  (par_typ),
        .rx_bus     (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Monitor
    int         tot_valid = 0;
    int         tot_par   = 0;
    int         tot_stp   = 0;
    int         pulse_cyc = 0;
    int         n_log     = 0;
    logic [7:0] log_q [8];

    always @(negedge clk) begin
        if (bus.data_valid) begin
            tot_valid = tot_valid + 1;
            if (n_log < 8) log_q[n_log] = bus.data;
            n_log = n_log + 1;
        end
        if (bus.par_err) tot_par = tot_par + 1;
        if (bus.stp_err) tot_stp = tot_stp + 1;
        if (bus.data_valid || bus.par_err || bus.stp_err) pulse_cyc = cyc;
    end

    int n_assert = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // Called on a falling edge; leaves the line high at the end of the stop bit.
    task automatic send_frame(input logic [7:0] b, input int p, input logic pe,
                              input logic pbit, input logic stop_bit, output int start_cyc);
        start_cyc = cyc;
        rx_in = 1'b0;
        repeat (p) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (p) @(negedge clk);
        end
        if (pe) begin
            rx_in = pbit;
            repeat (p) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (p) @(negedge clk);
        rx_in = 1'b1;
    endtask

    int n0, n1, v0, p0, s0;

    initial begin
        rst_n    = 1'b0;
        rx_in    = 1'b1;
        prescale = 6'd8;
        par_en   = 1'b0;
        par_typ  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_data",  32'(bus.data), 32'h00);
        check("rst_valid", 32'(bus.data_valid), 32'd0);
        check("rst_par",   32'(bus.par_err), 32'd0);
        check("rst_stp",   32'(bus.stp_err), 32'd0);
        rst_n = 1'b1;
        idle(10);

        // P=8, no parity, 0xA5
        v0 = tot_valid; p0 = tot_par; s0 = tot_stp;
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1, n0);
        idle(20);
        check("a5_data",  32'(bus.data), 32'hA5);
        check("a5_valid", 32'(tot_valid - v0), 32'd1);
        check("a5_errs",  32'((tot_par - p0) + (tot_stp - s0)), 32'd0);
        check("a5_when",  32'(pulse_cyc - n0), 32'd81);

        // P=16, even parity, 0x3C, parity bit 0
        prescale = 6'd16; par_en = 1'b1; par_typ = 1'b0;
        v0 = tot_valid; p0 = tot_par;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, n0);
        idle(40);
        check("even_data",  32'(bus.data), 32'h3C);
        check("even_valid", 32'(tot_valid - v0), 32'd1);
        check("even_par",   32'(tot_par - p0), 32'd0);
        check("even_when",  32'(pulse_cyc - n0), 32'd173);

        // P=16, odd parity, 0x3C, parity bit 0 -> parity error
        par_typ = 1'b1;
        v0 = tot_valid; p0 = tot_par;
        send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, n0);
        idle(40);
        check("odd_par",   32'(tot_par - p0), 32'd1);
        check("odd_valid", 32'(tot_valid - v0), 32'd0);
        check("odd_data",  32'(bus.data), 32'h3C);

        // P=32, stop bit low, 0xFF -> stop error
        prescale = 6'd32; par_en = 1'b0; par_typ = 1'b0;
        v0 = tot_valid; s0 = tot_stp;
        send_frame(8'hFF, 32, 1'b0, 1'b0, 1'b0, n0);
        idle(100);
        check("stp_err",   32'(tot_stp - s0), 32'd1);
        check("stp_valid", 32'(tot_valid - v0), 32'd0);
        check("stp_data",  32'(bus.data), 32'hFF);
        check("stp_when",  32'(pulse_cyc - n0), 32'd309);

        // P=8: 2-cycle glitch, then 0x55 and 0xAA back-to-back
        prescale = 6'd8;
        v0 = tot_valid; p0 = tot_par; s0 = tot_stp;
        rx_in = 1'b0;
        repeat (2) @(negedge clk);
        idle(40);
        check("glitch_pulses", 32'((tot_valid - v0) + (tot_par - p0) + (tot_stp - s0)), 32'd0);
        v0 = tot_valid;
        n_log = 0;
        send_frame(8'h55, 8, 1'b0, 1'b0, 1'b1, n0);
        send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b1, n1);
        idle(20);
        check("b2b_valid", 32'(tot_valid - v0), 32'd2);
        check("b2b_first", 32'(log_q[0]), 32'h55);
        check("b2b_second", 32'(log_q[1]), 32'hAA);
        check("b2b_when",  32'(pulse_cyc - n1), 32'd81);
        check("b2b_gap",   32'(n1 - n0), 32'd80);

        // P=6: smallest even step above the minimum
        prescale = 6'd6;
        v0 = tot_valid;
        send_frame(8'h81, 6, 1'b0, 1'b0, 1'b1, n0);
        idle(20);
        check("p6_data",  32'(bus.data), 32'h81);
        check("p6_valid", 32'(tot_valid - v0), 32'd1);

        // Illegal prescales 7 and 2: receiver stays idle
        v0 = tot_valid; p0 = tot_par; s0 = tot_stp;
        prescale = 6'd7;
        send_frame(8'h00, 7, 1'b0, 1'b0, 1'b1, n0);
        idle(20);
        prescale = 6'd2;
        send_frame(8'h0F, 2, 1'b0, 1'b0, 1'b1, n0);
        idle(20);
        check("illegal_pulses", 32'((tot_valid - v0) + (tot_par - p0) + (tot_stp - s0)), 32'd0);
        check("illegal_data",   32'(bus.data), 32'h81);

        // Reset mid-frame at P=8, then 0x12
        prescale = 6'd8;
        v0 = tot_valid; p0 = tot_par; s0 = tot_stp;
        rx_in = 1'b0;
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        rx_in = 1'b1;
        #1;
        check("midrst_data",  32'(bus.data), 32'h00);
        check("midrst_pulse", 32'({bus.data_valid, bus.par_err, bus.stp_err}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle(100);
        check("midrst_nopulse", 32'((tot_valid - v0) + (tot_par - p0) + (tot_stp - s0)), 32'd0);
        send_frame(8'h12, 8, 1'b0, 1'b0, 1'b1, n0);
        idle(20);
        check("post_rst_data",  32'(bus.data), 32'h12);
        check("post_rst_valid", 32'(tot_valid - v0), 32'd1);
        check("post_rst_when",  32'(pulse_cyc - n0), 32'd81);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
